// File: rtl/seq_cla_subtractor_pkg.sv
// Shared types and constants for the sequential group-lookahead add/subtract unit.
package seq_cla_pkg;

    localparam int unsigned GRP_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned ngrp);
        return (ngrp > 1) ? $clog2(ngrp) : 1;
    endfunction

endpackage

// File: rtl/seq_cla_subtractor_if.sv
// Operand/result handshake bundle for seq_cla_subtractor.
interface seq_cla_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             op_sub_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;
    logic             zero_o;

    modport master (
        output in_valid_i, a_i, b_i, op_sub_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, zero_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, op_sub_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o, zero_o
    );
endinterface

// File: rtl/seq_cla_subtractor_cla_group_4bit.sv
// One 4-bit carry-lookahead group: sum bits, group propagate/generate and carry-out.
module cla_group_4bit
    import seq_cla_pkg::*;
(
    input  logic [GRP_W-1:0] a_i,
    input  logic [GRP_W-1:0] b_i,
    input  logic             cin_i,
    output logic [GRP_W-1:0] sum_o,
    output logic             p_o,
    output logic             g_o,
    output logic             cout_o
);
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] c;

    always_comb begin
        p    = a_i ^ b_i;
        g    = a_i & b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
        sum_o  = p ^ c;
        p_o    = &p;
        g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        cout_o = g_o | (p_o & cin_i);
    end
endmodule

// File: rtl/seq_cla_subtractor.sv
// Multi-cycle add/subtract: one 4-bit lookahead group per cycle, LSB group first,
// with a registered carry linking consecutive groups.
module seq_cla_subtractor
    import seq_cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    seq_cla_subtractor_if.slave bus
);
    localparam int unsigned NGRP = WIDTH / GRP_W;
    localparam int unsigned IDXW = idx_width(NGRP);
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NGRP - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [GRP_W-1:0] grp_a, grp_b, grp_sum;
    logic             grp_p, grp_g, grp_cout;
    logic             unused_grp_pg;

    assign grp_a = a_q[idx_q*GRP_W +: GRP_W];
    assign grp_b = b_q[idx_q*GRP_W +: GRP_W];

    cla_group_4bit u_group (
        .a_i    (grp_a),
        .b_i    (grp_b),
        .cin_i  (carry_q),
        .sum_o  (grp_sum),
        .p_o    (grp_p),
        .g_o    (grp_g),
        .cout_o (grp_cout)
    );

    // Group P/G are exposed for a future multi-group lookahead; the single group chains via cout.
    assign unused_grp_pg = grp_p ^ grp_g;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    // Subtract as A + ~B + 1: invert B here, the +1 enters as carry-in.
                    a_d     = bus.a_i;
                    b_d     = bus.b_i ^ {WIDTH{bus.op_sub_i}};
                    carry_d = bus.op_sub_i;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q*GRP_W +: GRP_W] = grp_sum;
                carry_d = grp_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = grp_cout;
                    // Carry into the MSB is a^b^s at that bit; XOR with carry-out gives overflow.
                    ovf_d   = grp_a[GRP_W-1] ^ grp_b[GRP_W-1] ^ grp_sum[GRP_W-1] ^ grp_cout;
                    zero_d  = (sum_d == '0);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready_o  = (state_q == StIdle);
    assign bus.out_valid_o = (state_q == StDone);
    assign bus.sum_o       = sum_q;
    assign bus.cout_o      = cout_q;
    assign bus.ovf_o       = ovf_q;
    assign bus.zero_o      = zero_q;
endmodule

// File: doc/seq_cla_subtractor.md
Name: seq_cla_subtractor

Overview:
Multi-cycle WIDTH-bit add/subtract unit that processes one 4-bit lookahead group per cycle, LSB group first.
- A registered carry links consecutive groups.
- Subtraction is computed as A + ~B + 1. Borrow is reported as the inverse of the final carry.
- The unit sits beside the single-cycle lookahead adder as the area-reduced arithmetic option, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4 and ≥ 8
NGRP, WIDTH/4, number of 4-bit groups (derived localparam, not overridable)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous active-low reset
in_valid_i  input  1  operands/op valid
in_ready_o  output  1  unit can accept an operation
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
op_sub_i  input  1  0 = A+B, 1 = A−B
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  A±B modulo 2^WIDTH
cout_o  output  1  carry out of the MSB group (borrow = ~cout_o when op_sub)
ovf_o  output  1  signed overflow
zero_o  output  1  sum_o == 0

Behaviour:
- Reset (rst_ni low at a clock edge):
  - State goes to IDLE.
  - out_valid_o, sum_o, cout_o, ovf_o and zero_o all go to 0. in_ready_o goes to 1.
  - The group index and the carry register are cleared.
  - Reset wins over any in-flight operation. The partial result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i=1, latch A, B^{WIDTH{op_sub_i}} and op_sub_i. Set carry = op_sub_i and group index = 0. Go to RUN.
- RUN:
  - in_ready_o = 0.
  - Each cycle, group k = index computes bits [4k+3:4k] from the latched operands and the carry register.
  - Group P = AND of bit propagates. Group G = G3 | P3G2 | P3P2G1 | P3P2P1G0.
  - Carry-out = G | (P & carry).
  - Write the 4 sum bits into the result register and update the carry register.
  - When k = NGRP−1:
    - Record cout and ovf (carry into bit WIDTH−1 XOR carry out of bit WIDTH−1).
    - Compute zero from the completed result.
    - Go to DONE.
  - Otherwise increment k.
- DONE:
  - out_valid_o = 1 and the result outputs are stable.
  - Holds indefinitely while out_ready_i = 0.
  - On out_ready_i = 1, go to IDLE and drop out_valid_o at that edge.
  - in_ready_o = 0 in DONE. No new operation is accepted in the same cycle as result handoff.
- Latency: the accept edge is cycle 0. out_valid_o rises at edge NGRP (edge 8 for WIDTH=32).
- Throughput: one operation per NGRP+2 cycles at best.
- Result register: sum_o comes directly from the result register. Bits of groups not yet processed are don't-care while out_valid_o = 0; the bench must not check them.
- Operand isolation: in_valid_i, a_i and b_i are ignored outside IDLE. Changes to them during RUN or DONE do not affect the result.
- Arithmetic: all arithmetic is modulo 2^WIDTH.
  - Add: cout_o = unsigned carry.
  - Sub: cout_o = 1 means no borrow (A ≥ B unsigned).

Decomposition:
- Package seq_cla_pkg:
  - state enum type (IDLE, RUN, DONE)
  - GRP_W = 4 constant
  - function for group index width, $clog2(NGRP)
- Sub-module cla_group_4bit: combinational, one instance, computes 4-bit sum, group P/G and carry-out from a, b and carry-in.
- Top module: FSM, operand/result registers, carry register, flags.

Test Plan:
- Add, WIDTH=32: A=0x0000_0001, B=0x0000_0001, op_sub=0 -> after 8 cycles sum=0x0000_0002, cout=0, ovf=0, zero=0.
- Full carry ripple across all groups: A=0xFFFF_FFFF, B=0x0000_0001, add -> sum=0x0000_0000, cout=1, ovf=0, zero=1.
- Sub with borrow: A=0x0000_0005, B=0x0000_0007, sub -> sum=0xFFFF_FFFE, cout=0, ovf=0. Then A=7, B=5 -> sum=2, cout=1.
- Signed overflow:
  - A=0x7FFF_FFFF, B=1, add -> sum=0x8000_0000, ovf=1.
  - A=0x8000_0000, B=1, sub -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Backpressure: hold out_ready_i=0 for 5 cycles after DONE and drive new in_valid_i with changing operands -> outputs stable, in_ready_o=0, no new accept. Release -> IDLE next cycle, in_ready_o=1.
- Reset mid-operation: rst_ni low at cycle 3 of RUN -> next edge in IDLE, out_valid_o=0, all outputs 0. A fresh operation then completes correctly in 8 cycles.
